// File: rtl/odom_integrator_if.sv
// Velocity in / pose out bundle for the odometry integrator.
// Master drives velocities and control, slave returns the pose.
interface odom_integrator_if #(
  parameter int DATAWIDTH_N = 32
);
  logic                   ODOM_INTEGRATOR_ENABLE_In;
  logic                   ODOM_INTEGRATOR_SETBEGIN_InLow;
  logic                   ODOM_INTEGRATOR_VALID_In;
  logic [DATAWIDTH_N-1:0] ODOM_INTEGRATOR_VX_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_INTEGRATOR_VY_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_INTEGRATOR_WZ_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_INTEGRATOR_POSX_OutBus;
  logic [DATAWIDTH_N-1:0] ODOM_INTEGRATOR_POSY_OutBus;
  logic [DATAWIDTH_N-1:0] ODOM_INTEGRATOR_THETA_OutBus;
  logic                   ODOM_INTEGRATOR_BUSY_Out;
  logic                   ODOM_INTEGRATOR_DONE_Out;
  logic                   ODOM_INTEGRATOR_OVERRUN_Out;

  modport master (
    output ODOM_INTEGRATOR_ENABLE_In,
    output ODOM_INTEGRATOR_SETBEGIN_InLow,
    output ODOM_INTEGRATOR_VALID_In,
    output ODOM_INTEGRATOR_VX_InBus,
    output ODOM_INTEGRATOR_VY_InBus,
    output ODOM_INTEGRATOR_WZ_InBus,
    input  ODOM_INTEGRATOR_POSX_OutBus,
    input  ODOM_INTEGRATOR_POSY_OutBus,
    input  ODOM_INTEGRATOR_THETA_OutBus,
    input  ODOM_INTEGRATOR_BUSY_Out,
    input  ODOM_INTEGRATOR_DONE_Out,
    input  ODOM_INTEGRATOR_OVERRUN_Out
  );

  modport slave (
    input  ODOM_INTEGRATOR_ENABLE_In,
    input  ODOM_INTEGRATOR_SETBEGIN_InLow,
    input  ODOM_INTEGRATOR_VALID_In,
    input  ODOM_INTEGRATOR_VX_InBus,
    input  ODOM_INTEGRATOR_VY_InBus,
    input  ODOM_INTEGRATOR_WZ_InBus,
    output ODOM_INTEGRATOR_POSX_OutBus,
    output ODOM_INTEGRATOR_POSY_OutBus,
    output ODOM_INTEGRATOR_THETA_OutBus,
    output ODOM_INTEGRATOR_BUSY_Out,
    output ODOM_INTEGRATOR_DONE_Out,
    output ODOM_INTEGRATOR_OVERRUN_Out
  );
endinterface

// File: rtl/odom_integrator.sv
// Dead-reckoning pose integrator: x, y and wrapped heading from
// global-frame velocities, one sequenced update per sample tick.
module odom_integrator #(
  parameter int DATAWIDTH_N   = 32,
  parameter int FRACTIONAL_Q  = 15,
  parameter int DT_SHIFT      = 6,
  parameter int SAMPLE_CYCLES = 781250,
  parameter int TWO_PI        =
    $rtoi(6.283185307179586 * (2.0 ** FRACTIONAL_Q) + 0.5)
) (
  input logic ODOM_INTEGRATOR_CLOCK_50,
  input logic ODOM_INTEGRATOR_Reset_InHigh,
  odom_integrator_if.slave bus
);
  localparam int N  = DATAWIDTH_N;
  localparam int CW =
    (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic signed [N-1:0] TWO  = N'(TWO_PI);
  localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ACC_X, ACC_Y, ACC_T, WRAP, DONE
  } state_t;

  logic clk, rst;
  assign clk = ODOM_INTEGRATOR_CLOCK_50;
  assign rst = ODOM_INTEGRATOR_Reset_InHigh;

  logic setb, enable, valid;
  assign setb   = bus.ODOM_INTEGRATOR_SETBEGIN_InLow;
  assign enable = bus.ODOM_INTEGRATOR_ENABLE_In;
  assign valid  = bus.ODOM_INTEGRATOR_VALID_In;

  state_t state;
  logic [CW-1:0] cnt;
  logic tick;
  logic signed [N-1:0] vx_h, vy_h, wz_h;
  logic signed [N-1:0] sx, sy, sw;
  logic signed [N-1:0] posx, posy, theta;
  logic busy, done, overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_h <= '0;
      vy_h <= '0;
      wz_h <= '0;
    end else if (valid) begin
      vx_h <= bus.ODOM_INTEGRATOR_VX_InBus;
      vy_h <= bus.ODOM_INTEGRATOR_VY_InBus;
      wz_h <= bus.ODOM_INTEGRATOR_WZ_InBus;
    end
  end

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!setb) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // One adder serves every update step; WRAP reuses it for +/-2pi.
  logic signed [N-1:0] a_op, b_op;
  logic signed [N:0]   sum;
  logic signed [N-1:0] sat;

  always_comb begin
    a_op = posx;
    b_op = sx >>> DT_SHIFT;
    unique case (state)
      ACC_Y: begin
        a_op = posy;
        b_op = sy >>> DT_SHIFT;
      end
      ACC_T: begin
        a_op = theta;
        b_op = sw >>> DT_SHIFT;
      end
      WRAP: begin
        a_op = theta;
        if (theta >= TWO)
          b_op = -TWO;
        else if (theta < 0)
          b_op = TWO;
        else
          b_op = '0;
      end
      default: ;
    endcase
  end

  assign sum = {a_op[N-1], a_op} + {b_op[N-1], b_op};

  always_comb begin
    sat = sum[N-1:0];
    if (sum[N] != sum[N-1])
      sat = sum[N] ? SMIN : SMAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sx      <= '0;
      sy      <= '0;
      sw      <= '0;
      posx    <= '0;
      posy    <= '0;
      theta   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else if (!setb) begin
      state   <= IDLE;
      posx    <= '0;
      posy    <= '0;
      theta   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (tick && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick) begin
            sx    <= vx_h;
            sy    <= vy_h;
            sw    <= wz_h;
            busy  <= 1'b1;
            state <= ACC_X;
          end
        end
        ACC_X: begin
          posx  <= sat;
          state <= ACC_Y;
        end
        ACC_Y: begin
          posy  <= sat;
          state <= ACC_T;
        end
        ACC_T: begin
          theta <= sum[N-1:0];
          state <= WRAP;
        end
        WRAP: begin
          theta <= sum[N-1:0];
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ODOM_INTEGRATOR_POSX_OutBus  = posx;
  assign bus.ODOM_INTEGRATOR_POSY_OutBus  = posy;
  assign bus.ODOM_INTEGRATOR_THETA_OutBus = theta;
  assign bus.ODOM_INTEGRATOR_BUSY_Out     = busy;
  assign bus.ODOM_INTEGRATOR_DONE_Out     = done;
  assign bus.ODOM_INTEGRATOR_OVERRUN_Out  = overrun;
endmodule

// File: tb/tb_odom_integrator.sv
// Directed bench for odom_integrator: latency, wrap, saturation,
// clear, async reset and overrun with hand-computed expectations.
module tb_odom_integrator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  odom_integrator_if #(.DATAWIDTH_N(32)) ia();
  odom_integrator_if #(.DATAWIDTH_N(32)) ib();

  odom_integrator #(.SAMPLE_CYCLES(8)) dut_a (
    .ODOM_INTEGRATOR_CLOCK_50    (clk),
    .ODOM_INTEGRATOR_Reset_InHigh(rst),
    .bus                         (ia.slave)
  );

  odom_integrator #(.SAMPLE_CYCLES(4)) dut_b (
    .ODOM_INTEGRATOR_CLOCK_50    (clk),
    .ODOM_INTEGRATOR_Reset_InHigh(rst),
    .bus                         (ib.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!ia.ODOM_INTEGRATOR_DONE_Out && cnt < 40);
    if (!ia.ODOM_INTEGRATOR_DONE_Out)
      check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [31:0] vx,
                      input logic [31:0] vy,
                      input logic [31:0] wz);
    ia.ODOM_INTEGRATOR_VX_InBus = vx;
    ia.ODOM_INTEGRATOR_VY_InBus = vy;
    ia.ODOM_INTEGRATOR_WZ_InBus = wz;
    ia.ODOM_INTEGRATOR_VALID_In = 1'b1;
    cyc();
    ia.ODOM_INTEGRATOR_VALID_In = 1'b0;
  endtask

  task automatic clear_load(input logic [31:0] vx,
                            input logic [31:0] vy,
                            input logic [31:0] wz);
    ia.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b0;
    load(vx, vy, wz);
    ia.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b1;
  endtask

  initial begin
    ia.ODOM_INTEGRATOR_ENABLE_In      = 1'b0;
    ia.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b1;
    ia.ODOM_INTEGRATOR_VALID_In       = 1'b0;
    ia.ODOM_INTEGRATOR_VX_InBus       = '0;
    ia.ODOM_INTEGRATOR_VY_InBus       = '0;
    ia.ODOM_INTEGRATOR_WZ_InBus       = '0;
    ib.ODOM_INTEGRATOR_ENABLE_In      = 1'b0;
    ib.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b1;
    ib.ODOM_INTEGRATOR_VALID_In       = 1'b0;
    ib.ODOM_INTEGRATOR_VX_InBus       = '0;
    ib.ODOM_INTEGRATOR_VY_InBus       = '0;
    ib.ODOM_INTEGRATOR_WZ_InBus       = '0;

    repeat (2) cyc();
    check("rst_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0);
    check("rst_posy", ia.ODOM_INTEGRATOR_POSY_OutBus, 32'h0);
    check("rst_theta", ia.ODOM_INTEGRATOR_THETA_OutBus, 32'h0);
    check("rst_busy", {31'd0, ia.ODOM_INTEGRATOR_BUSY_Out}, 32'd0);
    check("rst_done", {31'd0, ia.ODOM_INTEGRATOR_DONE_Out}, 32'd0);
    check("rst_ovr", {31'd0, ia.ODOM_INTEGRATOR_OVERRUN_Out}, 32'd0);
    rst = 1'b0;

    // vx = 1.0: +1/64 m per tick, done 5 cycles after tick
    load(32'h0000_8000, 32'h0, 32'h0);
    ia.ODOM_INTEGRATOR_ENABLE_In = 1'b1;
    wait_done(n);
    check("lat_first", n, 32'd12);
    check("x1_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0000_0200);
    check("x1_posy", ia.ODOM_INTEGRATOR_POSY_OutBus, 32'h0);
    check("x1_busy", {31'd0, ia.ODOM_INTEGRATOR_BUSY_Out}, 32'd1);
    cyc();
    check("done_pulse", {31'd0, ia.ODOM_INTEGRATOR_DONE_Out}, 32'd0);
    check("busy_off", {31'd0, ia.ODOM_INTEGRATOR_BUSY_Out}, 32'd0);
    wait_done(n);
    check("period", n, 32'd7);
    repeat (2) wait_done(n);
    check("x4_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0000_0800);

    // heading wraps below zero and exactly at 2pi
    clear_load(32'h0, 32'h0, 32'hFFFF_8000);
    check("clr_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0);
    wait_done(n);
    check("clr_lat", n, 32'd12);
    check("th_neg", ia.ODOM_INTEGRATOR_THETA_OutBus, 32'd205375);
    check("th_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0);
    load(32'h0, 32'h0, 32'h0000_8000);
    wait_done(n);
    check("th_lat", n, 32'd7);
    check("th_2pi", ia.ODOM_INTEGRATOR_THETA_OutBus, 32'd0);

    // positive and negative saturation
    clear_load(32'h7FFF_FFFF, 32'h0, 32'h0);
    repeat (64) wait_done(n);
    check("sat_p64", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h7FFF_FFC0);
    wait_done(n);
    check("sat_p65", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h7FFF_FFFF);
    wait_done(n);
    check("sat_p66", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h7FFF_FFFF);
    clear_load(32'h8000_0000, 32'h0, 32'h0);
    repeat (64) wait_done(n);
    check("sat_n64", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h8000_0000);
    wait_done(n);
    check("sat_n65", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h8000_0000);
    check("sat_posy", ia.ODOM_INTEGRATOR_POSY_OutBus, 32'h0);

    // pose clear while in ACC_Y
    clear_load(32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000);
    repeat (9) cyc();
    check("accy_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0000_0200);
    check("accy_posy", ia.ODOM_INTEGRATOR_POSY_OutBus, 32'h0);
    ia.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b0;
    cyc();
    ia.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b1;
    check("sb_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0);
    check("sb_theta", ia.ODOM_INTEGRATOR_THETA_OutBus, 32'h0);
    check("sb_busy", {31'd0, ia.ODOM_INTEGRATOR_BUSY_Out}, 32'd0);
    check("sb_done", {31'd0, ia.ODOM_INTEGRATOR_DONE_Out}, 32'd0);
    wait_done(n);
    check("sb_relat", n, 32'd12);
    check("sb_posx2", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0000_0200);
    check("sb_posy2", ia.ODOM_INTEGRATOR_POSY_OutBus, 32'hFFFF_FE00);
    check("sb_th2", ia.ODOM_INTEGRATOR_THETA_OutBus, 32'h0000_0200);

    // asynchronous reset in ACC_T
    clear_load(32'h0000_8000, 32'h0, 32'h0);
    repeat (10) cyc();
    check("acct_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0000_0200);
    #2 rst = 1'b1;
    #1;
    check("ar_posx", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0);
    check("ar_busy", {31'd0, ia.ODOM_INTEGRATOR_BUSY_Out}, 32'd0);
    check("ar_done", {31'd0, ia.ODOM_INTEGRATOR_DONE_Out}, 32'd0);
    cyc();
    check("ar_hold", {31'd0, ia.ODOM_INTEGRATOR_DONE_Out}, 32'd0);
    rst = 1'b0;
    load(32'h0000_8000, 32'h0, 32'h0);
    wait_done(n);
    check("ar_lat", n, 32'd11);
    check("ar_posx2", ia.ODOM_INTEGRATOR_POSX_OutBus, 32'h0000_0200);

    // 4-cycle ticks against a 5-cycle sequence
    ib.ODOM_INTEGRATOR_ENABLE_In = 1'b1;
    repeat (7) cyc();
    check("ovr_pre", {31'd0, ib.ODOM_INTEGRATOR_OVERRUN_Out}, 32'd0);
    cyc();
    check("ovr_set", {31'd0, ib.ODOM_INTEGRATOR_OVERRUN_Out}, 32'd1);
    repeat (10) cyc();
    check("ovr_sticky", {31'd0, ib.ODOM_INTEGRATOR_OVERRUN_Out}, 32'd1);
    ib.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b0;
    cyc();
    ib.ODOM_INTEGRATOR_SETBEGIN_InLow = 1'b1;
    check("ovr_clr", {31'd0, ib.ODOM_INTEGRATOR_OVERRUN_Out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/odom_integrator.md
ODOM_INTEGRATOR -- requirements
Module: odom_integrator

Interface
REQ-001 SHALL provide parameters: DATAWIDTH_N, default 32, word width; FRACTIONAL_Q, default 15, fractional bits, all data signed two's complement S(N,Q); DT_SHIFT, default 6, integration period dt = 2^-DT_SHIFT s; SAMPLE_CYCLES, default 781250, clock cycles per integration tick; TWO_PI, default round(2*pi*2^FRACTIONAL_Q) = 205887, theta wrap limit.
REQ-002 SHALL have ports, one per line:
ODOM_INTEGRATOR_CLOCK_50  in  1  single system clock, all logic on rising edge
ODOM_INTEGRATOR_Reset_InHigh  in  1  asynchronous, active-high reset
ODOM_INTEGRATOR_ENABLE_In  in  1  high = tick counter runs; low = counter holds
ODOM_INTEGRATOR_SETBEGIN_InLow  in  1  synchronous active-low pose clear
ODOM_INTEGRATOR_VALID_In  in  1  velocity bus qualifier
ODOM_INTEGRATOR_VX_InBus  in  N  global vx [m/s]
ODOM_INTEGRATOR_VY_InBus  in  N  global vy [m/s]
ODOM_INTEGRATOR_WZ_InBus  in  N  global wz [rad/s]
ODOM_INTEGRATOR_POSX_OutBus  out  N  x [m]
ODOM_INTEGRATOR_POSY_OutBus  out  N  y [m]
ODOM_INTEGRATOR_THETA_OutBus  out  N  heading [rad], range [0, TWO_PI)
ODOM_INTEGRATOR_BUSY_Out  out  1  update sequence in progress
ODOM_INTEGRATOR_DONE_Out  out  1  one-cycle pulse, pose updated
ODOM_INTEGRATOR_OVERRUN_Out  out  1  sticky, tick lost while busy

Function
REQ-003 SHALL load VX/VY/WZ into velocity holding registers on any cycle with VALID_In high; registers otherwise hold.
REQ-004 Tick counter SHALL count 0..SAMPLE_CYCLES-1 while ENABLE_In high, assert an internal tick in the cycle it equals SAMPLE_CYCLES-1, then wrap to 0.
REQ-005 FSM states SHALL be IDLE, ACC_X, ACC_Y, ACC_T, WRAP, DONE; IDLE->ACC_X on tick; ACC_X->ACC_Y->ACC_T->WRAP->DONE->IDLE unconditionally, one cycle each.
REQ-006 On IDLE->ACC_X SHALL snapshot holding registers; VALID_In during the sequence updates holding registers only and is used at the next tick.
REQ-007 ACC_X/ACC_Y SHALL add (v >>> DT_SHIFT) (arithmetic shift) to POSX/POSY through one shared N+1-bit adder, saturating to 0x7FFF_FFFF / 0x8000_0000 (N=32) on overflow.
REQ-008 ACC_T SHALL add (wz >>> DT_SHIFT) to theta; WRAP SHALL subtract TWO_PI if result >= TWO_PI, add TWO_PI if result < 0, else hold; |wz*dt| < TWO_PI is a usage constraint.
REQ-009 DONE_Out SHALL be high only in state DONE; latency tick -> DONE_Out = 5 cycles; BUSY_Out high in ACC_X..DONE.
REQ-010 Outputs SHALL be registers; POSX/POSY/THETA change only in their own ACC/WRAP state.
REQ-011 Tick occurring while not IDLE SHALL be dropped and set OVERRUN_Out; OVERRUN_Out clears only on reset or SETBEGIN_InLow low.
REQ-012 SETBEGIN_InLow low SHALL, next edge, zero POSX/POSY/THETA, clear OVERRUN_Out, force FSM to IDLE, and reset tick counter to 0; it overrides tick and any in-progress sequence (no DONE pulse).
REQ-013 ENABLE_In low SHALL freeze the counter only; an in-progress sequence completes.

Reset
REQ-014 Reset_InHigh SHALL asynchronously force: POSX/POSY/THETA = 0, holding and snapshot registers = 0, counter = 0, FSM = IDLE, BUSY_Out/DONE_Out/OVERRUN_Out = 0; asserted mid-sequence, sequence aborts with no DONE pulse.

Verification (N=32, Q=15, DT_SHIFT=6, SAMPLE_CYCLES=8)
REQ-015 vx=0x0000_8000 (1.0), VALID pulse, ENABLE high -> after first tick POSX=0x0000_0200, POSY=0, DONE pulse 5 cycles after tick; after 4 ticks POSX=0x0000_0800.
REQ-016 wz=0xFFFF_8000 (-1.0) from theta=0 -> THETA=205375 after one tick; wz=+1.0 from 205375 -> THETA=0 (wrap at 205887 not exceeded: 205887 exactly maps to 0).
REQ-017 vx=0x7FFF_FFFF, 65 ticks -> POSX saturates at 0x7FFF_FFFF and holds; vx=0x8000_0000 from 0 -> saturates at 0x8000_0000.
REQ-018 SETBEGIN_InLow low during ACC_Y -> POSX/POSY/THETA=0 next edge, no DONE pulse, counter restarts at 0; SAMPLE_CYCLES=4 with forced tick during BUSY -> OVERRUN_Out=1 until SETBEGIN.
REQ-019 Reset_InHigh asserted asynchronously between edges in ACC_T -> all outputs 0 immediately, no DONE; after release first DONE at counter tick + 5 cycles.
